// File: rtl/music_box_song_player_if.sv
// Note-table ROM bus between the song player and its per-song table.
//   rom_addr : table address, driven by the player (master)
//   rom_data : {note, duration}, driven by the table (slave), valid one
//              clock after rom_addr
interface music_box_song_player_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 18
);
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;

    modport master (output rom_addr, input  rom_data);
    modport slave  (input  rom_addr, output rom_data);
endinterface

// File: rtl/music_box_song_player.sv
// Song sequencer: while currentState == STATE_ID, walks the note table,
// gating each note for its duration in ms, then an optional silent gap.
// Ports:
//   clock_50Mhz, reset_n : clock, async active-low reset
//   tick_1Khz            : 1 ms strobe
//   currentState         : state controller state; activates this instance
//   loop_en              : restart at entry 0 instead of completing
//   pause                : freeze ms counting, gate held
//   rom                  : note-table bus (master side)
//   note_code, note_gate : current note and its gate
//   stateComplete        : song finished, held until the state is left
//   debugString          : {addr[7:0], fsm[3:0], ms_count[19:0]}
module music_box_song_player #(
    parameter int STATE_ID   = 1,
    parameter int NOTE_COUNT = 16,
    parameter int NOTE_W     = 6,
    parameter int DUR_W      = 12,
    parameter int GAP_MS     = 20
) (
    input  logic                    clock_50Mhz,
    input  logic                    reset_n,
    input  logic                    tick_1Khz,
    input  logic [4:0]              currentState,
    input  logic                    loop_en,
    input  logic                    pause,
    music_box_song_player_if.master rom,
    output logic [NOTE_W-1:0]       note_code,
    output logic                    note_gate,
    output logic                    stateComplete,
    output logic [31:0]             debugString
);
    localparam int ADDR_W = $clog2(NOTE_COUNT);
    localparam int GAP_W  = (GAP_MS > 0) ? $clog2(GAP_MS + 1) : 1;
    localparam int CNT_W  = (DUR_W > GAP_W) ? DUR_W : GAP_W;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NOTE_COUNT - 1);
    localparam logic [CNT_W-1:0]  GAP_LAST  = (GAP_MS > 0) ? CNT_W'(GAP_MS - 1) : '0;

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_FETCH = 4'd1,
        S_LOAD  = 4'd2,
        S_PLAY  = 4'd3,
        S_GAP   = 4'd4,
        S_DONE  = 4'd5
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q,  addr_d;
    logic [NOTE_W-1:0]   note_q,  note_d;
    logic                gate_q,  gate_d;
    logic                done_q,  done_d;
    logic [CNT_W-1:0]    cnt_q,   cnt_d;
    logic [DUR_W-1:0]    dur_q,   dur_d;

    logic                active;
    logic                tick_ok;
    logic                advance;
    logic [NOTE_W-1:0]   rom_note;
    logic [DUR_W-1:0]    rom_dur;
    logic [CNT_W-1:0]    dur_last;

    assign active   = (currentState == 5'(STATE_ID));
    assign tick_ok  = tick_1Khz && !pause;
    assign rom_note = rom.rom_data[NOTE_W+DUR_W-1:DUR_W];
    assign rom_dur  = rom.rom_data[DUR_W-1:0];
    // Only used in PLAY, where the latched duration is known to be nonzero.
    assign dur_last = CNT_W'(dur_q) - CNT_W'(1);

    always_ff @(posedge clock_50Mhz or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            note_q  <= '0;
            gate_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            dur_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            note_q  <= note_d;
            gate_q  <= gate_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
            dur_q   <= dur_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        note_d  = note_q;
        gate_d  = gate_q;
        done_d  = done_q;
        cnt_d   = cnt_q;
        dur_d   = dur_q;
        advance = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (active) begin
                    addr_d  = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: state_d = S_LOAD;
            S_LOAD: begin
                dur_d = rom_dur;
                if (rom_dur == '0) begin
                    // zero duration marks the end of the song
                    gate_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    note_d  = rom_note;
                    cnt_d   = '0;
                    gate_d  = 1'b1;
                    state_d = S_PLAY;
                end
            end
            S_PLAY: begin
                if (tick_ok) begin
                    if (cnt_q == dur_last) begin
                        gate_d = 1'b0;
                        cnt_d  = '0;
                        if (GAP_MS > 0) state_d = S_GAP;
                        else            advance = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_GAP: begin
                if (tick_ok) begin
                    if (cnt_q == GAP_LAST) begin
                        cnt_d   = '0;
                        advance = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_DONE: begin
                // loop_en is deliberately ignored here
                gate_d = 1'b0;
                done_d = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        if (advance) begin
            if (addr_q == LAST_ADDR) begin
                if (loop_en) begin
                    addr_d  = '0;
                    state_d = S_FETCH;
                end else begin
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end
            end else begin
                addr_d  = addr_q + ADDR_W'(1);
                state_d = S_FETCH;
            end
        end

        // Leaving the state beats everything, including a coincident tick.
        if (!active) begin
            state_d = S_IDLE;
            addr_d  = '0;
            note_d  = '0;
            gate_d  = 1'b0;
            done_d  = 1'b0;
            cnt_d   = '0;
            dur_d   = '0;
        end
    end

    assign rom.rom_addr  = addr_q;
    assign note_code     = note_q;
    assign note_gate     = gate_q;
    assign stateComplete = done_q;
    assign debugString   = {8'(addr_q), state_q, 20'(cnt_q)};
endmodule

// File: tb/tb_music_box_song_player.sv
module tb_music_box_song_player;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        tick;
    logic [4:0]  cs;
    logic        loop_en;
    logic        pause;

    logic [5:0]  note_a, note_b;
    logic        gate_a, gate_b, done_a, done_b;
    logic [31:0] dbg_a, dbg_b;

    logic [17:0] tbl_a [4];
    logic [17:0] tbl_b [4];

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    music_box_song_player_if #(.ADDR_W(2), .DATA_W(18)) if_a ();
    music_box_song_player_if #(.ADDR_W(2), .DATA_W(18)) if_b ();

    always_ff @(posedge clk) if_a.rom_data <= tbl_a[if_a.rom_addr];
    always_ff @(posedge clk) if_b.rom_data <= tbl_b[if_b.rom_addr];

    music_box_song_player #(.STATE_ID(1), .NOTE_COUNT(4), .NOTE_W(6), .DUR_W(12), .GAP_MS(1)) dut_a (
        .clock_50Mhz(clk), .reset_n(rst_n), .tick_1Khz(tick), .currentState(cs),
        .loop_en(loop_en), .pause(pause), .rom(if_a), .note_code(note_a),
        .note_gate(gate_a), .stateComplete(done_a), .debugString(dbg_a));

    music_box_song_player #(.STATE_ID(1), .NOTE_COUNT(4), .NOTE_W(6), .DUR_W(12), .GAP_MS(0)) dut_b (
        .clock_50Mhz(clk), .reset_n(rst_n), .tick_1Khz(tick), .currentState(cs),
        .loop_en(loop_en), .pause(pause), .rom(if_b), .note_code(note_b),
        .note_gate(gate_b), .stateComplete(done_b), .debugString(dbg_b));

    typedef struct {
        logic        cs;
        logic        tick;
        logic        loop;
        logic        gate;
        logic [5:0]  note;
        logic        done;
        logic [1:0]  addr;
        logic [3:0]  fsm;
        logic [19:0] ms;
    } vec_t;

    vec_t vecs [16];

    function automatic vec_t mk(input logic c, input logic t, input logic l, input logic g,
                                input int n, input logic d, input int a, input int f, input int m);
        vec_t v;
        v.cs = c; v.tick = t; v.loop = l; v.gate = g; v.note = 6'(n);
        v.done = d; v.addr = 2'(a); v.fsm = 4'(f); v.ms = 20'(m);
        return v;
    endfunction

    function automatic logic [17:0] ent(input int n, input int d);
        return {6'(n), 12'(d)};
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // One clock: inputs change on the falling edge, outputs sampled 1 after the rising edge.
    task automatic step(input logic c, input logic t);
        @(negedge clk);
        cs   = c ? 5'd1 : 5'd0;
        tick = t;
        @(posedge clk);
        #1;
        chk("excl_a", 64'(gate_a & done_a), 64'd0);
        chk("excl_b", 64'(gate_b & done_b), 64'd0);
    endtask

    initial begin
        int   rises;
        int   hi;
        logic seen_done;
        logic seen_gate;
        logic prev_gate;

        rst_n = 1'b0; cs = 5'd0; tick = 1'b0; loop_en = 1'b0; pause = 1'b0;
        tbl_a[0] = ent(5, 3); tbl_a[1] = ent(9, 2); tbl_a[2] = ent(0, 0); tbl_a[3] = ent(0, 0);
        for (int i = 0; i < 4; i++) tbl_b[i] = ent(i + 1, 1);

        //              cs tk lp gt note dn ad fsm ms
        vecs[0]  = mk(1, 0, 0, 0, 0, 0, 0, 1, 0);
        vecs[1]  = mk(1, 0, 0, 0, 0, 0, 0, 2, 0);
        vecs[2]  = mk(1, 0, 0, 1, 5, 0, 0, 3, 0);
        vecs[3]  = mk(1, 1, 0, 1, 5, 0, 0, 3, 1);
        vecs[4]  = mk(1, 1, 0, 1, 5, 0, 0, 3, 2);
        vecs[5]  = mk(1, 1, 0, 0, 5, 0, 0, 4, 0);
        vecs[6]  = mk(1, 1, 0, 0, 5, 0, 1, 1, 0);
        vecs[7]  = mk(1, 0, 0, 0, 5, 0, 1, 2, 0);
        vecs[8]  = mk(1, 0, 0, 1, 9, 0, 1, 3, 0);
        vecs[9]  = mk(1, 1, 0, 1, 9, 0, 1, 3, 1);
        vecs[10] = mk(1, 1, 0, 0, 9, 0, 1, 4, 0);
        vecs[11] = mk(1, 1, 0, 0, 9, 0, 2, 1, 0);
        vecs[12] = mk(1, 0, 0, 0, 9, 0, 2, 2, 0);
        vecs[13] = mk(1, 0, 0, 0, 9, 1, 2, 5, 0);
        vecs[14] = mk(1, 1, 1, 0, 9, 1, 2, 5, 0);
        vecs[15] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);

        #22;
        chk("reset_a", {26'd0, gate_a, done_a, note_a, if_a.rom_addr, dbg_a}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // two-note song with gap, end marker, loop_en ignored in DONE, exit
        for (int i = 0; i < 16; i++) begin
            loop_en = vecs[i].loop;
            step(vecs[i].cs, vecs[i].tick);
            chk($sformatf("vec%0d", i),
                64'({gate_a, note_a, done_a, if_a.rom_addr, dbg_a[23:20], dbg_a[19:0], dbg_a[31:24]}),
                64'({vecs[i].gate, vecs[i].note, vecs[i].done, vecs[i].addr, vecs[i].fsm, vecs[i].ms,
                     6'd0, vecs[i].addr}));
        end
        loop_en = 1'b0;

        // full table, 1 ms notes, no gap, looping forever
        loop_en = 1'b1; rises = 0; seen_done = 1'b0; prev_gate = 1'b0;
        for (int c = 0; c < 40; c++) begin
            step(1'b1, 1'b1);
            if (done_b) seen_done = 1'b1;
            if (gate_b && !prev_gate) begin
                chk("loop_addr", 64'(if_b.rom_addr), 64'(rises % 4));
                chk("loop_note", 64'(note_b), 64'(rises % 4 + 1));
                rises++;
            end
            prev_gate = gate_b;
        end
        chk("loop_rises", 64'(rises), 64'd13);
        chk("loop_no_done", 64'(seen_done), 64'd0);
        loop_en = 1'b0;
        step(1'b0, 1'b0);

        // leave the state mid-note with a coincident tick, then re-enter
        tbl_a[0] = ent(7, 1); tbl_a[1] = ent(8, 10);
        repeat (3) step(1'b1, 1'b0);
        repeat (2) step(1'b1, 1'b1);
        repeat (2) step(1'b1, 1'b0);
        chk("mid_play", 64'({gate_a, note_a, if_a.rom_addr}), 64'({1'b1, 6'd8, 2'd1}));
        repeat (2) step(1'b1, 1'b1);
        chk("mid_ms", 64'(dbg_a[23:0]), 64'({4'd3, 20'd2}));
        step(1'b0, 1'b1);
        chk("exit_clear", 64'({gate_a, done_a, note_a, if_a.rom_addr, dbg_a}), 64'd0);
        repeat (3) step(1'b1, 1'b0);
        chk("reenter", 64'({gate_a, note_a, if_a.rom_addr}), 64'({1'b1, 6'd7, 2'd0}));
        step(1'b0, 1'b0);

        // pause for 10 ticks inside a 4 ms note
        tbl_a[0] = ent(3, 4); tbl_a[1] = ent(0, 0);
        repeat (3) step(1'b1, 1'b0);
        hi = 0;
        repeat (2) begin if (gate_a) hi++; step(1'b1, 1'b1); end
        pause = 1'b1;
        repeat (10) begin if (gate_a) hi++; step(1'b1, 1'b1); end
        chk("pause_hold", 64'({gate_a, dbg_a[19:0]}), 64'({1'b1, 20'd2}));
        pause = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (!gate_a) break;
            hi++;
            step(1'b1, 1'b1);
        end
        chk("pause_hi_ticks", 64'(hi), 64'd14);
        chk("pause_gate_off", 64'({gate_a, dbg_a[23:20]}), 64'({1'b0, 4'd4}));
        step(1'b1, 1'b1);
        repeat (2) step(1'b1, 1'b0);
        chk("pause_done", 64'({done_a, gate_a, if_a.rom_addr}), 64'({1'b1, 1'b0, 2'd1}));
        step(1'b0, 1'b0);

        // end marker at entry 0
        tbl_a[0] = ent(0, 0);
        step(1'b1, 1'b0);
        chk("em_c1", 64'({done_a, dbg_a[23:20]}), 64'({1'b0, 4'd1}));
        step(1'b1, 1'b0);
        chk("em_c2", 64'(done_a), 64'd0);
        step(1'b1, 1'b0);
        chk("em_c3", 64'({done_a, gate_a, dbg_a[23:20]}), 64'({1'b1, 1'b0, 4'd5}));
        seen_gate = 1'b0;
        repeat (5) begin step(1'b1, 1'b1); if (gate_a) seen_gate = 1'b1; end
        chk("em_no_gate", 64'({seen_gate, done_a}), 64'({1'b0, 1'b1}));
        step(1'b0, 1'b0);
        chk("em_exit", 64'(done_a), 64'd0);

        // async reset pulse in the gap after the second note
        tbl_a[0] = ent(4, 1); tbl_a[1] = ent(6, 2); tbl_a[2] = ent(0, 0);
        repeat (3) step(1'b1, 1'b0);
        repeat (2) step(1'b1, 1'b1);
        repeat (2) step(1'b1, 1'b0);
        repeat (2) step(1'b1, 1'b1);
        chk("gap_pre", 64'({note_a, if_a.rom_addr, dbg_a[23:20], gate_a}),
            64'({6'd6, 2'd1, 4'd4, 1'b0}));
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst", 64'({gate_a, done_a, note_a, if_a.rom_addr, dbg_a}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cs    = 5'd1;
        tick  = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_restart", 64'({if_a.rom_addr, dbg_a[23:20]}), 64'({2'd0, 4'd1}));
        repeat (2) step(1'b1, 1'b0);
        chk("rst_first_note", 64'({gate_a, note_a, if_a.rom_addr}), 64'({1'b1, 6'd4, 2'd0}));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
